// File: rtl/deser_pkg.sv
// Shared defaults and helpers for the multi-lane serial-to-parallel deserialiser.
package deser_pkg;

   localparam int DEF_WIDTH      = 16;
   localparam int DEF_LANES      = 4;
   localparam int DEF_PHASE_STEP = 4;
   localparam int DEF_FIFO_DEPTH = 2;

   // Width of a lane index; a single lane still gets a 1-bit index.
   function automatic int lane_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/deser_lane.sv
// One serial lane: MSB-first shift register, word-boundary counter with bitslip,
// and a small word FIFO with a sticky drop flag.
module deser_lane
   import deser_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PHASE_STEP = DEF_PHASE_STEP,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int LANE_IDX   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             din,
   input  logic             bitslip,
   input  logic             pop,
   input  logic             clear_ovf,
   output logic             empty,
   output logic [WIDTH-1:0] head,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_INIT = CW'((LANE_IDX * PHASE_STEP) % WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr_reg;
   logic [CW-1:0]    cnt_reg;
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];

   logic             word_done;
   logic             full;
   logic             push;
   logic [WIDTH-1:0] word;

   // A slipping cycle still shifts data but does not advance the boundary.
   assign word_done = enable && !bitslip && (cnt_reg == CNT_LAST);
   assign word      = {sr_reg[WIDTH-2:0], din};
   assign empty     = (wr_ptr_reg == rd_ptr_reg);
   assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign push      = word_done && (!full || pop);
   assign head      = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_reg  <= '0;
         cnt_reg <= CNT_INIT;
      end else if (enable) begin
         sr_reg <= word;
         if (!bitslip)
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg[AW-1:0]] <= word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (word_done && full && !pop)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/multi_lane_deser.sv
// Multi-lane deserialiser: LANES independent lanes merged into one valid/ready
// word stream by a round-robin arbiter feeding a single output register.
module multi_lane_deser
   import deser_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LANES      = DEF_LANES,
   parameter int PHASE_STEP = DEF_PHASE_STEP,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [LANES-1:0]          din,
   input  logic [LANES-1:0]          bitslip,
   input  logic                      clear_ovf,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [WIDTH-1:0]          m_data,
   output logic [lane_w(LANES)-1:0]  m_lane,
   output logic [LANES-1:0]          overflow
);

   localparam int LW = lane_w(LANES);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

   logic [LANES-1:0] lane_empty;
   logic [LANES-1:0] lane_pop;
   logic [WIDTH-1:0] lane_head [LANES];
   logic [LW-1:0]    rr_ptr_reg;
   logic [LW-1:0]    grant_lane;
   logic             grant_valid;
   logic             load;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_pop[gi] = load && (grant_lane == LW'(gi));

         deser_lane #(
            .WIDTH      (WIDTH),
            .PHASE_STEP (PHASE_STEP),
            .FIFO_DEPTH (FIFO_DEPTH),
            .LANE_IDX   (gi)
         ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .din       (din[gi]),
            .bitslip   (bitslip[gi]),
            .pop       (lane_pop[gi]),
            .clear_ovf (clear_ovf),
            .empty     (lane_empty[gi]),
            .head      (lane_head[gi]),
            .overflow  (overflow[gi])
         );
      end
   endgenerate

   // Walk offsets from farthest to nearest so the nearest non-empty lane after
   // the last grant wins; offset LANES revisits the last granted lane last.
   always_comb begin
      grant_valid = 1'b0;
      grant_lane  = '0;
      for (int k = LANES; k >= 1; k--) begin
         int idx;
         idx = (int'(rr_ptr_reg) + k) % LANES;
         if (!lane_empty[idx]) begin
            grant_valid = 1'b1;
            grant_lane  = idx[LW-1:0];
         end
      end
   end

   assign load = (!m_valid || m_ready) && grant_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_lane     <= '0;
         rr_ptr_reg <= LAST_LANE;
      end else if (load) begin
         m_valid    <= 1'b1;
         m_data     <= lane_head[grant_lane];
         m_lane     <= grant_lane;
         rr_ptr_reg <= grant_lane;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_lane_deser.sv
// Directed self-checking bench for multi_lane_deser at its default configuration.
module tb_multi_lane_deser;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  din = '0;
   logic [3:0]  bitslip = '0;
   logic        clear_ovf = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [15:0] m_data;
   logic [1:0]  m_lane;
   logic [3:0]  overflow;

   int total = 0;
   int bad = 0;

   multi_lane_deser #(
      .WIDTH(16), .LANES(4), .PHASE_STEP(4), .FIFO_DEPTH(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .din       (din),
      .bitslip   (bitslip),
      .clear_ovf (clear_ovf),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_lane    (m_lane),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Bit k (0 = first sent) of a 16-bit word sent MSB-first.
   function automatic logic wbit(input logic [15:0] w, input int k);
      return w[15 - (k % 16)];
   endfunction

   task automatic apply_reset;
      reset = 1'b1; enable = 1'b0; din = '0; bitslip = '0;
      clear_ovf = 1'b0; m_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #1;
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
      total++;
      if (m_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", m_data); end
      total++;
      if (m_lane !== 2'd0) begin bad++; $display("FAIL reset_lane: got %0d want 0", m_lane); end
      total++;
      if (overflow !== 4'b0000) begin bad++; $display("FAIL reset_ovf: got %b want 0000", overflow); end
      $display("reset: valid=%b data=%h lane=%0d ovf=%b", m_valid, m_data, m_lane, overflow);
      apply_reset();
   endtask

   // Lane 0 carries 0xA5C3, lanes 1..3 carry all ones; phase offsets 0,4,8,12
   // make lanes 3,2,1,0 complete after 4,8,12,16 bits.
   task automatic run_power_up_seq(input string tag);
      logic        exp_v;
      logic [1:0]  exp_l;
      logic [15:0] exp_d;
      enable = 1'b1; m_ready = 1'b1; bitslip = '0;
      for (int e = 1; e <= 17; e++) begin
         din = {3'b111, wbit(16'hA5C3, e - 1)};
         tick();
         exp_v = 1'b1;
         case (e)
            5:       begin exp_l = 2'd3; exp_d = 16'h000F; end
            9:       begin exp_l = 2'd2; exp_d = 16'h00FF; end
            13:      begin exp_l = 2'd1; exp_d = 16'h0FFF; end
            17:      begin exp_l = 2'd0; exp_d = 16'hA5C3; end
            default: begin exp_v = 1'b0; exp_l = 2'd0; exp_d = 16'h0000; end
         endcase
         total++;
         if (m_valid !== exp_v) begin
            bad++;
            $display("FAIL %s_valid edge %0d: got %b want %b", tag, e, m_valid, exp_v);
         end
         if (exp_v) begin
            total++;
            if (m_lane !== exp_l || m_data !== exp_d) begin
               bad++;
               $display("FAIL %s_word edge %0d: got lane %0d data %h want lane %0d data %h",
                        tag, e, m_lane, m_data, exp_l, exp_d);
            end
            $display("%s: edge %0d lane %0d data %h", tag, e, m_lane, m_data);
         end
      end
      enable = 1'b0;
      din = '0;
   endtask

   task automatic test_first_word;
      run_power_up_seq("first_word");
   endtask

   // 0x00FF repeating on lane 0, one slip at edge 20: boundary moves one bit later.
   task automatic test_bitslip;
      logic [15:0] exp_d [3];
      int          exp_e [3];
      int          n = 0;
      exp_d[0] = 16'h00FF; exp_e[0] = 17;
      exp_d[1] = 16'h01FE; exp_e[1] = 34;
      exp_d[2] = 16'h01FE; exp_e[2] = 50;
      apply_reset();
      enable = 1'b1;
      for (int e = 1; e <= 52; e++) begin
         din = {3'b000, wbit(16'h00FF, e - 1)};
         bitslip = (e == 20) ? 4'b0001 : 4'b0000;
         tick();
         if (m_valid && m_lane == 2'd0) begin
            total++;
            if (n >= 3) begin
               bad++;
               $display("FAIL bitslip_extra: edge %0d data %h want no more words", e, m_data);
            end else if (m_data !== exp_d[n] || e != exp_e[n]) begin
               bad++;
               $display("FAIL bitslip_word%0d: got %h at edge %0d want %h at edge %0d",
                        n, m_data, e, exp_d[n], exp_e[n]);
            end
            $display("bitslip: edge %0d data %h", e, m_data);
            n++;
         end
      end
      total++;
      if (n != 3) begin bad++; $display("FAIL bitslip_count: got %0d want 3", n); end
      bitslip = '0; enable = 1'b0; din = '0;
   endtask

   // Back-pressure: output reg + 2-deep FIFO absorb three words, the fourth drops.
   task automatic test_overflow;
      logic [15:0] words [4];
      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
      apply_reset();
      m_ready = 1'b0;
      bitslip = 4'b1110;
      enable = 1'b1;
      for (int e = 1; e <= 64; e++) begin
         din = {3'b000, wbit(words[(e - 1) / 16], e - 1)};
         tick();
         if (e == 17 || e == 40 || e == 64) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== 16'h1111 || m_lane !== 2'd0) begin
               bad++;
               $display("FAIL ovf_hold edge %0d: got v=%b data %h lane %0d want v=1 data 1111 lane 0",
                        e, m_valid, m_data, m_lane);
            end
         end
         if (e == 48) begin
            total++;
            if (overflow !== 4'b0000) begin bad++; $display("FAIL ovf_early: got %b want 0000", overflow); end
         end
         if (e == 64) begin
            total++;
            if (overflow !== 4'b0001) begin bad++; $display("FAIL ovf_set: got %b want 0001", overflow); end
         end
      end
      $display("overflow: after 4 words ovf=%b data %h", overflow, m_data);
      enable = 1'b0; bitslip = '0; din = '0;
      m_ready = 1'b1;
      tick();
      total++;
      if (m_valid !== 1'b1 || m_data !== 16'h2222) begin
         bad++; $display("FAIL ovf_drain1: got v=%b data %h want v=1 data 2222", m_valid, m_data);
      end
      tick();
      total++;
      if (m_valid !== 1'b1 || m_data !== 16'h3333) begin
         bad++; $display("FAIL ovf_drain2: got v=%b data %h want v=1 data 3333", m_valid, m_data);
      end
      tick();
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain_end: got v=%b want 0", m_valid); end
      total++;
      if (overflow !== 4'b0001) begin bad++; $display("FAIL ovf_sticky: got %b want 0001", overflow); end
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      total++;
      if (overflow !== 4'b0000) begin bad++; $display("FAIL ovf_clear: got %b want 0000", overflow); end
      $display("overflow: drained, after clear ovf=%b", overflow);
   endtask

   // Lane 2 slips 8 bits to align with lane 0, then slips 16 more so lane 0
   // wins alone once before the second simultaneous completion.
   task automatic test_arbitration;
      int          exp_e [5];
      logic [1:0]  exp_l [5];
      logic [15:0] exp_d [5];
      logic [15:0] w0;
      logic [15:0] w2;
      logic        slip2;
      int          n = 0;
      exp_e[0] = 17; exp_l[0] = 2'd0; exp_d[0] = 16'h1234;
      exp_e[1] = 18; exp_l[1] = 2'd2; exp_d[1] = 16'h5678;
      exp_e[2] = 33; exp_l[2] = 2'd0; exp_d[2] = 16'h9ABC;
      exp_e[3] = 49; exp_l[3] = 2'd2; exp_d[3] = 16'hC3A5;
      exp_e[4] = 50; exp_l[4] = 2'd0; exp_d[4] = 16'h0F0F;
      apply_reset();
      enable = 1'b1;
      for (int e = 1; e <= 52; e++) begin
         w0 = (e <= 16) ? 16'h1234 : (e <= 32) ? 16'h9ABC : 16'h0F0F;
         w2 = (e <= 16) ? 16'h5678 : (e <= 32) ? 16'h0000 : 16'hC3A5;
         slip2 = (e <= 8) || (e > 16 && e <= 32);
         din = {1'b0, wbit(w2, e - 1), 1'b0, wbit(w0, e - 1)};
         bitslip = {1'b1, slip2, 1'b1, 1'b0};
         tick();
         if (m_valid) begin
            total++;
            if (n >= 5) begin
               bad++;
               $display("FAIL arb_extra: edge %0d lane %0d data %h", e, m_lane, m_data);
            end else if (e != exp_e[n] || m_lane !== exp_l[n] || m_data !== exp_d[n]) begin
               bad++;
               $display("FAIL arb_word%0d: got edge %0d lane %0d data %h want edge %0d lane %0d data %h",
                        n, e, m_lane, m_data, exp_e[n], exp_l[n], exp_d[n]);
            end
            $display("arbitration: edge %0d lane %0d data %h", e, m_lane, m_data);
            n++;
         end
      end
      total++;
      if (n != 5) begin bad++; $display("FAIL arb_count: got %0d want 5", n); end
      enable = 1'b0; bitslip = '0; din = '0;
   endtask

   task automatic test_reset_midword;
      apply_reset();
      m_ready = 1'b0;
      enable = 1'b1;
      din = 4'b1111;
      repeat (8) tick();
      total++;
      if (m_valid !== 1'b1 || m_lane !== 2'd3) begin
         bad++; $display("FAIL midreset_pre: got v=%b lane %0d want v=1 lane 3", m_valid, m_lane);
      end
      reset = 1'b1;
      #1;
      total++;
      if (m_valid !== 1'b0 || overflow !== 4'b0000 || m_data !== 16'h0000) begin
         bad++;
         $display("FAIL midreset_async: got v=%b ovf=%b data %h want v=0 ovf=0000 data 0000",
                  m_valid, overflow, m_data);
      end
      $display("midword reset: valid=%b ovf=%b", m_valid, overflow);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_ready = 1'b1;
      run_power_up_seq("after_reset");
   endtask

   initial begin
      test_reset();
      test_first_word();
      test_bitslip();
      test_overflow();
      test_arbitration();
      test_reset_midword();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
